// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO and launch sequencer feeding a UART transmitter
// Optional flush port enabled by defining UART_TX_FIFO_FLUSH_EN.
module uart_tx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
`ifdef UART_TX_FIFO_FLUSH_EN
    input  logic              i_flush,
`endif
    input  logic              i_wr_en,
    input  logic [7:0]        i_wr_data,
    output logic              o_full,
    output logic              o_empty,
    output logic [ADDR_W:0]   o_count,
    output logic              o_overflow,
    output logic              o_tx_dv,
    output logic [7:0]        o_tx_byte,
    input  logic              i_tx_active,
    input  logic              i_tx_done
);
    localparam logic [ADDR_W-1:0] PTR_ONE  = 1;
    localparam logic [ADDR_W:0]   CNT_ONE  = 1;
    localparam logic [ADDR_W:0]   CNT_FULL = DEPTH[ADDR_W:0];

    typedef enum logic [1:0] {
        IDLE,
        WAIT_DONE,
        GAP
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [7:0]          mem [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   rd_ptr;
    logic [ADDR_W:0]     count_next;
    logic                launch;
    logic                push;
    logic                flush;

`ifdef UART_TX_FIFO_FLUSH_EN
    assign flush = i_flush;
`else
    assign flush = 1'b0;
`endif

    assign push = i_wr_en && !o_full && !flush;

    // Launch only when the transmitter is fully quiet, so a frame left running
    // across a reset is never overrun.
    always_comb begin
        state_next = state;
        launch     = 1'b0;
        case (state)
            IDLE: begin
                if (!o_empty && !i_tx_active && !i_tx_done) begin
                    launch     = 1'b1;
                    state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (i_tx_done) begin
                    state_next = GAP;
                end
            end
            GAP: begin
                if (!i_tx_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        count_next = o_count;
        if (push && !launch) begin
            count_next = o_count + CNT_ONE;
        end else if (!push && launch) begin
            count_next = o_count - CNT_ONE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_count    <= '0;
            o_empty    <= 1'b1;
            o_full     <= 1'b0;
            o_overflow <= 1'b0;
            o_tx_dv    <= 1'b0;
            o_tx_byte  <= 8'h00;
        end else begin
            state   <= state_next;
            o_tx_dv <= launch;
            if (i_wr_en && o_full && !flush) begin
                o_overflow <= 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (launch) begin
                o_tx_byte <= mem[rd_ptr];
            end
            if (flush) begin
                rd_ptr  <= wr_ptr;
                o_count <= '0;
                o_empty <= 1'b1;
                o_full  <= 1'b0;
            end else begin
                if (launch) begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                end
                o_count <= count_next;
                o_empty <= (count_next == '0);
                o_full  <= (count_next == CNT_FULL);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= i_wr_data;
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - randomized scoreboard bench for uart_tx_fifo with a UART transmitter model
module tb_uart_tx_fifo;
    localparam int DEPTH = 16;
    localparam int CPB   = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full, empty, ovf, tx_dv;
    logic [4:0] count;
    logic [7:0] tx_byte;
    logic       tx_active, tx_done;

    logic       m_active = 1'b0;
    logic       m_done = 1'b0;
    logic       force_active = 1'b0;
    int         bit_cnt = 0;
    int         done_cnt = 0;
    logic       frame_open = 1'b0;
    logic       prev_dv = 1'b0;
    logic [7:0] last_byte = 8'h00;
    logic [7:0] q[$];
    logic       exp_ovf = 1'b0;
    int         checks = 0;
    int         errors = 0;

    assign tx_active = m_active | force_active;
    assign tx_done   = m_done;

    always #5 clk = ~clk;

    uart_tx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
`ifdef UART_TX_FIFO_FLUSH_EN
        .i_flush     (1'b0),
`endif
        .i_wr_en     (wr_en),
        .i_wr_data   (wr_data),
        .o_full      (full),
        .o_empty     (empty),
        .o_count     (count),
        .o_overflow  (ovf),
        .o_tx_dv     (tx_dv),
        .o_tx_byte   (tx_byte),
        .i_tx_active (tx_active),
        .i_tx_done   (tx_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor plus transmitter model: checks use what the DUT saw at the last edge,
    // then the transmitter advances one cycle.
    always @(negedge clk) begin
        if (rst) last_byte = 8'h00;
        if (tx_dv) begin
            chk("launch_tx_quiet", 32'({tx_active, tx_done}), 32'd0);
            chk("launch_after_done_fell", 32'(frame_open), 32'd0);
            chk("dv_one_cycle", 32'(prev_dv), 32'd0);
            chk("launch_has_byte", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) chk("byte_order", 32'(tx_byte), 32'(q.pop_front()));
            last_byte  = tx_byte;
            frame_open = 1'b1;
        end else begin
            chk("byte_hold", 32'(tx_byte), 32'(last_byte));
        end
        chk("count", 32'(count), 32'(q.size()));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("full", 32'(full), 32'(q.size() == DEPTH));
        chk("overflow", 32'(ovf), 32'(exp_ovf));
        prev_dv = tx_dv;

        if (tx_dv) begin
            bit_cnt  = 10 * CPB;
            m_active = 1'b1;
        end else if (bit_cnt > 0) begin
            bit_cnt--;
            if (bit_cnt == 0) begin
                m_active = 1'b0;
                m_done   = 1'b1;
                done_cnt = 2;
            end
        end else if (done_cnt > 0) begin
            done_cnt--;
            if (done_cnt == 0) begin
                m_done     = 1'b0;
                frame_open = 1'b0;
            end
        end
    end

    task automatic step(input logic en, input logic [7:0] d);
        @(negedge clk);
        #1;
        wr_en   = en;
        wr_data = d;
        if (en) begin
            if (q.size() < DEPTH) q.push_back(d);
            else exp_ovf = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 8'h00);
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || frame_open || m_active || m_done) && n < 3000) begin
            step(1'b0, 8'h00);
            n++;
        end
        chk("drain_in_time", 32'(n < 3000), 32'd1);
        idle(2);
    endtask

    initial begin
        idle(2);
        chk("reset_dv", 32'(tx_dv), 32'd0);
        chk("reset_byte", 32'(tx_byte), 32'd0);
        chk("reset_overflow", 32'(ovf), 32'd0);
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_empty", 32'(empty), 32'd1);
        chk("reset_full", 32'(full), 32'd0);
        rst = 1'b0;
        idle(2);

        // Single byte: launch visible two edges after the write.
        step(1'b1, 8'hA5);
        step(1'b0, 8'h00);
        chk("single_dv_early", 32'(tx_dv), 32'd0);
        step(1'b0, 8'h00);
        chk("single_dv", 32'(tx_dv), 32'd1);
        chk("single_byte", 32'(tx_byte), 32'hA5);
        drain();
        chk("single_count_end", 32'(count), 32'd0);

        // Burst of five consecutive writes.
        for (int i = 1; i <= 5; i++) step(1'b1, 8'(i));
        step(1'b0, 8'h00);
        drain();
        chk("burst_count_end", 32'(count), 32'd0);

        // Simultaneous write and pop with three bytes queued.
        force_active = 1'b1;
        step(1'b1, 8'h11);
        step(1'b1, 8'h22);
        step(1'b1, 8'h33);
        idle(2);
        chk("simul_pre_count", 32'(count), 32'd3);
        step(1'b1, 8'h77);
        force_active = 1'b0;
        step(1'b0, 8'h00);
        chk("simul_dv", 32'(tx_dv), 32'd1);
        chk("simul_count", 32'(count), 32'd3);
        drain();

        // Wrap-around: 40 random bytes with partial drains between blocks.
        for (int b = 0; b < 5; b++) begin
            int lim;
            int n;
            for (int i = 0; i < 8; i++) begin
                step(1'b1, 8'($urandom));
                if ($urandom_range(0, 2) == 0) step(1'b0, 8'h00);
            end
            step(1'b0, 8'h00);
            lim = $urandom_range(0, 3);
            n = 0;
            while (q.size() > lim && n < 2000) begin
                step(1'b0, 8'h00);
                n++;
            end
            chk("wrap_partial_drain", 32'(n < 2000), 32'd1);
        end
        drain();

        // Full and overflow with the transmitter held busy.
        force_active = 1'b1;
        for (int i = 0; i < 16; i++) step(1'b1, 8'($urandom));
        step(1'b0, 8'h00);
        chk("full_flag", 32'(full), 32'd1);
        chk("full_count", 32'(count), 32'd16);
        chk("full_no_ovf_yet", 32'(ovf), 32'd0);
        step(1'b1, 8'hEE);
        step(1'b0, 8'h00);
        chk("ovf_set", 32'(ovf), 32'd1);
        chk("ovf_count", 32'(count), 32'd16);
        force_active = 1'b0;
        drain();
        chk("ovf_sticky", 32'(ovf), 32'd1);

        // Reset while a frame is in flight with four bytes queued.
        for (int i = 0; i < 5; i++) step(1'b1, 8'hC0 + 8'(i));
        step(1'b0, 8'h00);
        idle(2);
        chk("mid_count", 32'(count), 32'd4);
        chk("mid_tx_active", 32'(tx_active), 32'd1);
        rst = 1'b1;
        q.delete();
        exp_ovf = 1'b0;
        step(1'b0, 8'h00);
        rst = 1'b0;
        chk("mid_reset_count", 32'(count), 32'd0);
        chk("mid_reset_ovf", 32'(ovf), 32'd0);
        step(1'b1, 8'h3C);
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        chk("mid_no_launch_busy", 32'(tx_dv), 32'd0);
        drain();
        chk("mid_final_count", 32'(count), 32'd0);
        chk("mid_final_byte", 32'(tx_byte), 32'h3C);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
